// File: rtl/alu_share_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_pkg : shared widths, ALU function codes and FSM encoding. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_share_ctrl_pkg;

  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_FUNC_W = 6;

  localparam logic [C_FUNC_W-1:0] C_FUNC_ADD  = 6'b000010;
  localparam logic [C_FUNC_W-1:0] C_FUNC_ADDI = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_if : requester/response/ALU bundle. rsp_ovf present with ALU_SHARE_OVF_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_share_ctrl_if
  import alu_share_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [C_DATA_W*N_REQ-1:0] req_a;
  logic [C_DATA_W*N_REQ-1:0] req_b;
  logic [C_FUNC_W*N_REQ-1:0] req_func;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready;
  logic [C_DATA_W-1:0]       rsp_data;
  logic [C_DATA_W-1:0]       alu_a;
  logic [C_DATA_W-1:0]       alu_b;
  logic [C_FUNC_W-1:0]       alu_func;
  logic [C_DATA_W-1:0]       alu_out;
`ifdef ALU_SHARE_OVF_EN
  logic                      rsp_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_func, rsp_ovf
  );

  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_func, rsp_ovf
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_func, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_func
  );

  modport master (
    output req_valid, req_a, req_b, req_func, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_func
  );
`endif

endinterface

`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_rr_arbiter : combinational round-robin pick starting after i_last_gnt. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int GNT_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GNT_W-1:0] i_last_gnt,
  output logic [N_REQ-1:0] o_gnt_oh,
  output logic [GNT_W-1:0] o_gnt_idx,
  output logic             o_any
);

  always_comb begin
    logic [GNT_W-1:0] v_idx;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    v_idx     = '0;
    // Offset 1 first, offset N_REQ (the last winner itself) last.
    for (int i = 1; i <= N_REQ; i++) begin
      v_idx = GNT_W'((int'(i_last_gnt) + i) % N_REQ);
      if (!o_any && i_req[v_idx]) begin
        o_any     = 1'b1;
        o_gnt_idx = v_idx;
      end
    end
    o_gnt_oh[o_gnt_idx] = o_any;
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl : time-shares one combinational ALU among N_REQ requesters
// (IDLE -> EXEC -> RESP). Optional rsp_ovf with ALU_SHARE_OVF_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GNT_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  alu_share_ctrl_if.slave  io_bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GNT_W-1:0]     r_last_gnt;
  logic [GNT_W-1:0]     r_gnt;
  logic [GNT_W-1:0]     w_arb_idx;
  logic [N_REQ-1:0]     w_arb_oh;
  logic                 w_arb_any;
  logic [N_REQ-1:0]     w_req_ready;
  logic [N_REQ-1:0]     w_rsp_valid;
  logic [C_DATA_W-1:0]  r_op_a;
  logic [C_DATA_W-1:0]  r_op_b;
  logic [C_FUNC_W-1:0]  r_op_func;
  logic [C_DATA_W-1:0]  r_rsp_data;

  alu_share_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_arb (
    .i_req      (io_bus.req_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt_oh   (w_arb_oh),
    .o_gnt_idx  (w_arb_idx),
    .o_any      (w_arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // rsp_valid is decoded from state so an async reset drops it at once.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_ready = w_arb_oh;
        if (w_arb_any) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        w_rsp_valid[r_gnt] = 1'b1;
        if (io_bus.rsp_ready[r_gnt]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_gnt <= GNT_W'(N_REQ - 1);
      r_gnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_func  <= '0;
      r_rsp_data <= '0;
    end else begin
      if (r_state == ST_IDLE && w_arb_any) begin
        r_gnt     <= w_arb_idx;
        r_op_a    <= io_bus.req_a[C_DATA_W*w_arb_idx +: C_DATA_W];
        r_op_b    <= io_bus.req_b[C_DATA_W*w_arb_idx +: C_DATA_W];
        r_op_func <= io_bus.req_func[C_FUNC_W*w_arb_idx +: C_FUNC_W];
      end
      if (r_state == ST_EXEC) r_rsp_data <= io_bus.alu_out;
      if (r_state == ST_RESP && io_bus.rsp_ready[r_gnt]) r_last_gnt <= r_gnt;
    end
  end

`ifdef ALU_SHARE_OVF_EN
  logic [C_DATA_W:0] w_sum;
  logic              r_rsp_ovf;

  // Signed overflow: the sign-extended carry disagrees with the result sign.
  assign w_sum = {r_op_a[C_DATA_W-1], r_op_a} + {r_op_b[C_DATA_W-1], r_op_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_ovf <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_ovf <= (r_op_func == C_FUNC_ADD) ? (w_sum[C_DATA_W] ^ w_sum[C_DATA_W-1]) : 1'b0;
    end
  end

  assign io_bus.rsp_ovf = r_rsp_ovf;
`endif

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.alu_a     = r_op_a;
  assign io_bus.alu_b     = r_op_b;
  assign io_bus.alu_func  = r_op_func;

endmodule

`default_nettype wire
